dmem_responder: RTL and testbench

Word-addressed data-memory responder: the memory side of the core datapath's load/store port. It accepts one load/store request at a time, inserts a configurable number of wait states, commits the write or fetches the read word, and returns a response. Misaligned and out-of-range accesses produce an error response with no side effects. It sits between the datapath's data-address/data-write/data-read signals and the control unit, which stalls the core while `req_ready` or `rsp_valid` is low.

---
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory side of the core's load/store port. Takes one word-sized load or
//   store at a time, idles for WAIT_STATES cycles, then commits the store (or
//   fetches the load word) and holds a response until the consumer takes it.
//   Misaligned or out-of-window addresses return an error with no side effect.
//
// Parameters
//   BASE_ADDR    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles between accept and response (0..15)
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  block can accept a request this cycle
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address
//   req_wdata_i  store data
//   req_be_i     store byte enables, bit i -> wdata[8i+7:8i]
//   rsp_valid_o  response present
//   rsp_ready_i  consumer takes the response
//   rsp_rdata_o  load data, 0 for stores and errors
//   rsp_err_o    access was misaligned or out of range
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  // Window bounds in 33 bits so BASE_ADDR + size can never wrap past 2^32.
  localparam logic [32:0] LO_33 = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_33 = LO_33 + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_e      state_q;
  req_t        req_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  req_t             req_in;
  req_t             cur;
  logic             accept;
  logic             access;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             mem_we;
  logic [31:0]      acc_rdata;

  assign req_in = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};

  // req_ready_q is low in the first IDLE cycle after reset, which is what
  // keeps requests on the release edge from being taken.
  assign accept = (state_q == S_IDLE) && req_ready_q && req_valid_i;

  // With zero wait states the access edge is the accept edge itself, so the
  // access must look at the live inputs rather than the latched copy.
  assign cur = (state_q == S_IDLE) ? req_in : req_q;

  always_comb begin
    access = 1'b0;
    if (state_q == S_WAIT && cnt_q == 4'd1) access = 1'b1;
    if (accept && WS == 4'd0)               access = 1'b1;
  end

  assign acc_err = (cur.addr[1:0] != 2'b00)
                 || ({1'b0, cur.addr} <  LO_33)
                 || ({1'b0, cur.addr} >= HI_33);

  assign acc_idx   = IDX_W'((cur.addr - BASE_ADDR) >> 2);
  assign mem_we    = access && cur.we && !acc_err;
  assign acc_rdata = (!cur.we && !acc_err) ? mem[acc_idx] : 32'h0;

  // Array is deliberately not reset. A store only lands on the access edge,
  // so a reset during WAIT drops it before it touches memory.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur.be[b]) mem[acc_idx][8*b +: 8] <= cur.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_q       <= req_in;
            cnt_q       <= WS;
            req_ready_q <= 1'b0;
            if (WS == 4'd0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= acc_rdata;
              rsp_err_q   <= acc_err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= acc_rdata;
            rsp_err_q   <= acc_err;
          end
        end
        S_RESP: begin
          // Response held until taken; ready comes back on the same edge.
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Bench for dmem_responder. Three instances share clock and reset:
// d=0 WAIT_STATES=1, d=1 WAIT_STATES=0, d=2 WAIT_STATES=3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    dmem_responder #(
      .BASE_ADDR  (32'h1001_0000),
      .DEPTH_WORDS(1024),
      .WAIT_STATES(WS)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid[g]),
      .req_ready_o(req_ready[g]),
      .req_we_i   (req_we[g]),
      .req_addr_i (req_addr[g]),
      .req_wdata_i(req_wdata[g]),
      .req_be_i   (req_be[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_ready_i(rsp_ready[g]),
      .rsp_rdata_o(rsp_rdata[g]),
      .rsp_err_o  (rsp_err[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic void push_exp(input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    sb_q.push_back(e);
  endfunction

  // Full transaction; called at a negedge, returns at a negedge.
  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input string name);
    int   k;
    int   lat;
    exp_t e;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++; $display("FAIL %s accept: req_ready=%b required 1", name, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    push_exp(exp_rdata, exp_err);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs while the access is in flight; they must be ignored.
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = 4'hF;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    e = sb_q.pop_front();
    n_cmp++;
    if (lat != ws_of(d) + 1) begin
      n_fail++; $display("FAIL %s latency: got %0d edges required %0d", name, lat, ws_of(d) + 1);
    end
    if (rsp_valid[d] !== 1'b1) return;
    n_cmp++;
    if (rsp_rdata[d] !== e.rdata || rsp_err[d] !== e.err) begin
      n_fail++;
      $display("FAIL %s data: rdata=%h err=%b required rdata=%h err=%b",
               name, rsp_rdata[d], rsp_err[d], e.rdata, e.err);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    n_cmp++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake: rsp_valid=%b req_ready=%b required 0/1",
               name, rsp_valid[d], req_ready[d]);
    end
  endtask

  task automatic check_zero(input int d, input string name);
    n_cmp++;
    if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 ||
        rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s d%0d: ready=%b valid=%b rdata=%h err=%b required all 0",
               name, d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_zero(d, "reset_values");
    // Request present across the release edge must not be taken.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h1001_0002;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL release_ready: req_ready=%b required 0", req_ready[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL first_edge d%0d: ready=%b valid=%b required 1/0", d, req_ready[d], rsp_valid[d]);
      end
    end
    // Bring d0 into RESP with an error response, then reset mid-cycle.
    req_valid[0] = 1'b1; req_addr[0] = 32'h1001_0002; req_we[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_async valid=%b err=%b required 1/1", rsp_valid[0], rsp_err[0]);
    end
    #2 rst_n = 1'b0;
    #1 check_zero(0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "basic_store");
    issue(0, 1'b0, 32'h1001_0008, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "basic_load");
  endtask

  task automatic test_byte_enables();
    issue(0, 1'b1, 32'h1001_0010, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "be_full");
    issue(0, 1'b1, 32'h1001_0010, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, "be_0101");
    issue(0, 1'b0, 32'h1001_0010, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, "be_load");
    issue(0, 1'b1, 32'h1001_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, "be_none");
    issue(0, 1'b0, 32'h1001_0010, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "be_none_load");
  endtask

  task automatic test_errors();
    issue(0, 1'b1, 32'h1001_0000, 32'h5A5A_0001, 4'hF, 32'h0, 1'b0, "err_seed0");
    issue(0, 1'b1, 32'h1001_0FFC, 32'h0000_0077, 4'hF, 32'h0, 1'b0, "err_seed_last");
    issue(0, 1'b0, 32'h1001_0002, 32'h0, 4'hF, 32'h0, 1'b1, "err_misaligned_ld");
    issue(0, 1'b1, 32'h1001_0002, 32'hBAD0_0001, 4'hF, 32'h0, 1'b1, "err_misaligned_st");
    issue(0, 1'b1, 32'h1001_1000, 32'hBAD0_0002, 4'hF, 32'h0, 1'b1, "err_past_end");
    issue(0, 1'b0, 32'h1000_FFFC, 32'h0, 4'hF, 32'h0, 1'b1, "err_below_base");
    issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0, 1'b1, "err_no_wrap_ld");
    issue(0, 1'b1, 32'hFFFF_FFFC, 32'hBAD0_0003, 4'hF, 32'h0, 1'b1, "err_no_wrap_st");
    issue(0, 1'b0, 32'h1001_0000, 32'h0, 4'h0, 32'h5A5A_0001, 1'b0, "err_word0_intact");
    issue(0, 1'b0, 32'h1001_0FFC, 32'h0, 4'h0, 32'h0000_0077, 1'b0, "err_last_intact");
  endtask

  task automatic test_backpressure();
    exp_t e;
    issue(1, 1'b1, 32'h1001_0020, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, "bp_seed");
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h1001_0020; req_be[1] = 4'h0;
    push_exp(32'h0BAD_F00D, 1'b0);
    @(posedge clk);
    @(negedge clk);
    // Next request held on the bus throughout; RESP must ignore it.
    req_we[1] = 1'b1; req_addr[1] = 32'h1001_0024; req_wdata[1] = 32'h1357_9BDF; req_be[1] = 4'hF;
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== e.rdata || rsp_err[1] !== e.err ||
          req_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                 c, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1], e.rdata, e.err);
      end
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    n_cmp++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid=%b ready=%b required 0/1", rsp_valid[1], req_ready[1]);
    end
    push_exp(32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (rsp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0 || rsp_rdata[1] !== e.rdata ||
        rsp_err[1] !== e.err) begin
      n_fail++;
      $display("FAIL bp_next_accept: valid=%b ready=%b rdata=%h err=%b required 1/0/%h/%b",
               rsp_valid[1], req_ready[1], rsp_rdata[1], rsp_err[1], e.rdata, e.err);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 32'h1001_0024, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, "bp_next_load");
  endtask

  task automatic test_reset_wait();
    int stray;
    issue(2, 1'b1, 32'h1001_0040, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "rw_seed");
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h1001_0040;
    req_wdata[2] = 32'h1234_5678; req_be[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero(2, "rw_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid[2] !== 1'b0) stray++;
      @(negedge clk);
    end
    n_cmp++;
    if (stray != 0) begin
      n_fail++; $display("FAIL rw_stray_rsp: %0d cycles with rsp_valid, required 0", stray);
    end
    issue(2, 1'b0, 32'h1001_0040, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "rw_old_value");
    issue(0, 1'b0, 32'h1001_0008, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rw_mem_kept");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
